// File: rtl/dircc_router_arbiter.sv
// dircc_router_arbiter: packet-locked round-robin arbiter feeding the single dircc_router input stream
// Grant holds from startofpacket to endofpacket; a registered output stage tags each beat with its source.
module dircc_router_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int EMPTY_WIDTH = 1,
    localparam int CH_WIDTH   = $clog2(NUM_INPUTS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_INPUTS-1:0]             in_valid,
    output logic [NUM_INPUTS-1:0]             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_INPUTS-1:0]             in_startofpacket,
    input  logic [NUM_INPUTS-1:0]             in_endofpacket,
    input  logic [NUM_INPUTS*EMPTY_WIDTH-1:0] in_empty,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_startofpacket,
    output logic                              out_endofpacket,
    output logic [EMPTY_WIDTH-1:0]            out_empty,
    output logic [CH_WIDTH-1:0]               out_channel,
    output logic                              drop_pulse
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t                 state, next_state;
    logic [CH_WIDTH-1:0]    grant, last_grant, pick;
    logic                   found, take;
    logic [NUM_INPUTS-1:0]  cand;
    logic [DATA_WIDTH-1:0]  data_arr  [NUM_INPUTS];
    logic [EMPTY_WIDTH-1:0] empty_arr [NUM_INPUTS];

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_split
        assign data_arr[i]  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign empty_arr[i] = in_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
    end

    assign cand = in_valid & in_startofpacket;
    assign take = (state == LOCKED) && in_valid[grant] && in_ready[grant];

    // Descending scan so the nearest requester after last_grant wins.
    always_comb begin
        found = 1'b0;
        pick  = last_grant;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            if (cand[(int'(last_grant) + k) % NUM_INPUTS]) begin
                found = 1'b1;
                pick  = CH_WIDTH'((int'(last_grant) + k) % NUM_INPUTS);
            end
        end
    end

    // In IDLE only orphan beats are acknowledged (and discarded); SOP beats wait for the grant.
    always_comb begin
        next_state = state;
        in_ready   = '0;
        if (state == IDLE) begin
            in_ready = reset_n ? (in_valid & ~in_startofpacket) : '0;
            if (found) next_state = LOCKED;
        end else begin
            in_ready[grant] = !out_valid || out_ready;
            if (take && in_endofpacket[grant]) next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            grant             <= '0;
            last_grant        <= CH_WIDTH'(NUM_INPUTS - 1);
            drop_pulse        <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_empty         <= '0;
            out_channel       <= '0;
        end else begin
            state      <= next_state;
            drop_pulse <= (state == IDLE) && |(in_valid & in_ready);
            if (state == IDLE && found) grant <= pick;
            if (take && in_endofpacket[grant]) last_grant <= grant;
            if (take) begin
                out_valid         <= 1'b1;
                out_data          <= data_arr[grant];
                out_startofpacket <= in_startofpacket[grant];
                out_endofpacket   <= in_endofpacket[grant];
                out_empty         <= empty_arr[grant];
                out_channel       <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
